// File: rtl/periph_pkg.sv
// Shared definitions for the ID-tagged peripheral request/response protocol.
package periph_pkg;

  // Response opcode carried on r_opc.
  typedef enum logic {
    OPC_OK  = 1'b0,
    OPC_ERR = 1'b1
  } periph_opc_e;

endpackage : periph_pkg

// File: rtl/periph_target_id_if.sv
// Request/response bundle of the ID-tagged peripheral protocol.
// master drives the request and consumes the grant and response; slave is the target side.
interface periph_target_id_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);

  logic                  req;
  logic [ADDR_WIDTH-1:0] add;
  logic                  we_n;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_WIDTH-1:0]   be;
  logic [ID_WIDTH-1:0]   id;
  logic                  gnt;
  logic                  r_valid;
  logic                  r_opc;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_rdata;

  modport master (
    output req, add, we_n, wdata, be, id,
    input  gnt, r_valid, r_opc, r_id, r_rdata
  );

  modport slave (
    input  req, add, we_n, wdata, be, id,
    output gnt, r_valid, r_opc, r_id, r_rdata
  );

endinterface : periph_target_id_if

// File: rtl/fifo_v3.sv
// Synchronous FIFO with optional fall-through, flush and unpush (drop last pushed entry).
// Storage updates are qualified by write enables rather than gated clocks, so the
// test-mode clock-gating bypass has no effect on this implementation.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  unpush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH:0]   FIFO_DEPTH = (ADDR_DEPTH+1)'(DEPTH);
  localparam logic [ADDR_DEPTH:0]   CNT_ONE    = (ADDR_DEPTH+1)'(1);
  localparam logic [ADDR_DEPTH-1:0] PTR_ONE    = ADDR_DEPTH'(1);
  localparam logic [ADDR_DEPTH-1:0] PTR_LAST   = ADDR_DEPTH'(DEPTH - 1);

  logic [ADDR_DEPTH-1:0] read_ptr_q, read_ptr_n;
  logic [ADDR_DEPTH-1:0] write_ptr_q, write_ptr_n;
  logic [ADDR_DEPTH:0]   status_cnt_q, status_cnt_n;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;

  function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  function automatic logic [ADDR_DEPTH-1:0] ptr_dec(input logic [ADDR_DEPTH-1:0] p);
    return (p == '0) ? PTR_LAST : p - PTR_ONE;
  endfunction

  assign full_o  = (status_cnt_q == FIFO_DEPTH);
  assign empty_o = (status_cnt_q == '0) & ~(FALL_THROUGH & push_i);
  assign usage_o = status_cnt_q[ADDR_DEPTH-1:0];

  // Pointer and occupancy update for push, pop, fall-through and unpush.
  always_comb begin
    read_ptr_n   = read_ptr_q;
    write_ptr_n  = write_ptr_q;
    status_cnt_n = status_cnt_q;
    data_o       = mem_q[read_ptr_q];
    mem_we       = 1'b0;

    if (push_i && !full_o) begin
      mem_we       = 1'b1;
      write_ptr_n  = ptr_inc(write_ptr_q);
      status_cnt_n = status_cnt_q + CNT_ONE;
    end

    if (pop_i && !empty_o) begin
      read_ptr_n   = ptr_inc(read_ptr_q);
      status_cnt_n = status_cnt_n - CNT_ONE;
    end

    // Empty fall-through: data bypasses storage; a same-cycle pop consumes it outright.
    if (FALL_THROUGH && (status_cnt_q == '0) && push_i) begin
      data_o = data_i;
      if (pop_i) begin
        status_cnt_n = status_cnt_q;
        read_ptr_n   = read_ptr_q;
        write_ptr_n  = write_ptr_q;
        mem_we       = 1'b0;
      end
    end

    if (unpush_i && !push_i && (status_cnt_n != '0)) begin
      write_ptr_n  = ptr_dec(write_ptr_q);
      status_cnt_n = status_cnt_n - CNT_ONE;
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_ptr_q   <= '0;
      write_ptr_q  <= '0;
      status_cnt_q <= '0;
    end else if (flush_i) begin
      read_ptr_q   <= '0;
      write_ptr_q  <= '0;
      status_cnt_q <= '0;
    end else begin
      read_ptr_q   <= read_ptr_n;
      write_ptr_q  <= write_ptr_n;
      status_cnt_q <= status_cnt_n;
    end
  end

  // Entry storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[write_ptr_q] <= data_i;
    end
  end

endmodule : fifo_v3

// File: rtl/periph_target_id.sv
// Target-side responder for the ID-tagged peripheral protocol.
// Forwards requests to an in-order backend, queues accepted IDs and returns
// registered, ID-tagged responses one cycle after each backend rvalid.
// Optional feature macro: PERIPH_TARGET_ERR_EN (backend error reporting on r_opc
// and the sticky protocol-error flag).
module periph_target_id
  import periph_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned BYTE_ENABLE_BIT = DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   scan_ckgt_enable_i,
  periph_target_id_if.slave                      data,
  output logic                                   be_req_o,
  output logic [ADDR_WIDTH-1:0]                  be_add_o,
  output logic                                   be_we_n_o,
  output logic [DATA_WIDTH-1:0]                  be_wdata_o,
  output logic [BYTE_ENABLE_BIT-1:0]             be_be_o,
  input  logic                                   be_gnt_i,
  input  logic                                   be_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                  be_rdata_i,
  input  logic                                   be_err_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   proto_err_o
);

  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FIFO_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                  id_full;
  logic                  id_empty;
  logic [ID_WIDTH-1:0]   head_id;
  logic                  id_push;
  logic                  id_pop;
  logic [FIFO_AW-1:0]    usage_unused;
  logic [CNT_W-1:0]      cnt_q;
  logic                  r_valid_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [DATA_WIDTH-1:0] r_rdata_q;

  // Request path is purely combinational; id_full is the registered full flag, so
  // a pop in the same cycle cannot open the grant.
  assign be_req_o   = data.req & ~id_full;
  assign data.gnt   = be_req_o & be_gnt_i;
  assign be_add_o   = data.add;
  assign be_we_n_o  = data.we_n;
  assign be_wdata_o = data.wdata;
  assign be_be_o    = data.be;

  assign id_push = data.gnt;
  assign id_pop  = be_rvalid_i & ~id_empty;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (ID_WIDTH),
    .DEPTH        (MAX_OUTSTANDING)
  ) ID_FIFO (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .unpush_i   (1'b0),
    .testmode_i (scan_ckgt_enable_i),
    .full_o     (id_full),
    .empty_o    (id_empty),
    .usage_o    (usage_unused),
    .data_i     (data.id),
    .push_i     (id_push),
    .data_o     (head_id),
    .pop_i      (id_pop)
  );

  // Outstanding counter: grants increment, answered responses decrement.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      case ({id_push, id_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign outstanding_o = cnt_q;

  // Response stage: one-cycle valid pulse, payload held between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
      r_rdata_q <= '0;
    end else begin
      r_valid_q <= id_pop;
      if (id_pop) begin
        r_id_q    <= head_id;
        r_rdata_q <= be_rdata_i;
      end
    end
  end

  assign data.r_valid = r_valid_q;
  assign data.r_id    = r_id_q;
  assign data.r_rdata = r_rdata_q;

`ifdef PERIPH_TARGET_ERR_EN
  periph_opc_e r_opc_q;
  logic        proto_err_q;

  // Backend error captured alongside the response payload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_opc_q <= OPC_OK;
    end else if (id_pop) begin
      r_opc_q <= be_err_i ? OPC_ERR : OPC_OK;
    end
  end

  // Sticky flag for a backend response with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      proto_err_q <= 1'b0;
    end else if (be_rvalid_i && id_empty) begin
      proto_err_q <= 1'b1;
    end
  end

  assign data.r_opc  = r_opc_q;
  assign proto_err_o = proto_err_q;
`else
  logic unused_be_err;

  assign unused_be_err = be_err_i;
  assign data.r_opc    = OPC_OK;
  assign proto_err_o   = 1'b0;
`endif

endmodule : periph_target_id

// File: tb/tb_periph_target_id.sv
// Randomized scoreboard bench for periph_target_id.
// The reference model keeps the accepted IDs as an ordered list and derives
// grants, occupancy and expected responses from the protocol rules directly.
module tb_periph_target_id;
  import periph_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned IW   = 8;
  localparam int unsigned BW   = DW / 8;
  localparam int unsigned MAXO = 4;
  localparam int unsigned CW   = $clog2(MAXO + 1);
`ifdef PERIPH_TARGET_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scan_en = 1'b0;
  logic          be_req;
  logic [AW-1:0] be_add;
  logic          be_we_n;
  logic [DW-1:0] be_wdata;
  logic [BW-1:0] be_be;
  logic          be_gnt = 1'b0;
  logic          be_rvalid = 1'b0;
  logic [DW-1:0] be_rdata = '0;
  logic          be_err = 1'b0;
  logic [CW-1:0] outstanding;
  logic          proto_err;

  periph_target_id_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BE_WIDTH(BW)) dif ();

  periph_target_id #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .BYTE_ENABLE_BIT(BW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .scan_ckgt_enable_i(scan_en),
    .data(dif.slave),
    .be_req_o(be_req), .be_add_o(be_add), .be_we_n_o(be_we_n),
    .be_wdata_o(be_wdata), .be_be_o(be_be),
    .be_gnt_i(be_gnt), .be_rvalid_i(be_rvalid), .be_rdata_i(be_rdata), .be_err_i(be_err),
    .outstanding_o(outstanding), .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IW-1:0] id; int gcyc; } pend_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] rdata; logic opc; int due; } rsp_t;

  pend_t         model_ids[$];
  rsp_t          exp_q[$];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  bit            mon_en = 1'b0;
  bit            proto_cur = 1'b0;
  bit            proto_nxt = 1'b0;
  logic [IW-1:0] last_id = '0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_opc = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on each r_valid pulse, flags late or
  // missing responses, and checks the payload holds between pulses.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dif.r_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_r_valid", 32'(dif.r_valid), 32'd0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("r_latency", 32'(cyc), 32'(e.due));
          chk("r_id", 32'(dif.r_id), 32'(e.id));
          chk("r_rdata", dif.r_rdata, e.rdata);
          chk("r_opc", 32'(dif.r_opc), 32'(e.opc));
          last_id    = e.id;
          last_rdata = e.rdata;
          last_opc   = e.opc;
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          void'(exp_q.pop_front());
          chk("missing_r_valid", 32'(dif.r_valid), 32'd1);
        end
        chk("hold_r_id", 32'(dif.r_id), 32'(last_id));
        chk("hold_r_rdata", dif.r_rdata, last_rdata);
        chk("hold_r_opc", 32'(dif.r_opc), 32'(last_opc));
      end
    end
  end

  task automatic drive_idle();
    dif.req   = 1'b0;
    dif.add   = '0;
    dif.we_n  = 1'b1;
    dif.wdata = '0;
    dif.be    = '0;
    dif.id    = '0;
    be_gnt    = 1'b0;
    be_rvalid = 1'b0;
    be_rdata  = '0;
    be_err    = 1'b0;
  endtask

  // One clock of stimulus; the model predicts grant, occupancy and responses.
  task automatic do_cycle(input logic req, input logic [IW-1:0] id, input logic we_n,
                          input logic gnt, input logic rv, input logic [DW-1:0] rd,
                          input logic err);
    int  occ;
    bit  exp_gnt;
    bit  exp_req;
    @(posedge clk);
    #1;
    occ       = model_ids.size();
    exp_req   = req && (occ < MAXO);
    exp_gnt   = exp_req && gnt;
    proto_cur = proto_nxt;
    dif.req   = req;
    dif.id    = id;
    dif.we_n  = we_n;
    dif.add   = $urandom;
    dif.wdata = $urandom;
    dif.be    = BW'($urandom);
    be_gnt    = gnt;
    be_rvalid = rv;
    be_rdata  = rd;
    be_err    = err;
    if (rv) begin
      if (occ > 0) begin
        rsp_t e;
        e.id    = model_ids.pop_front().id;
        e.rdata = rd;
        e.opc   = ERR_EN ? err : 1'b0;
        e.due   = cyc + 1;
        exp_q.push_back(e);
      end else if (ERR_EN) begin
        proto_nxt = 1'b1;
      end
    end
    if (exp_gnt) model_ids.push_back('{id: id, gcyc: cyc});
    @(negedge clk);
    chk("gnt", 32'(dif.gnt), 32'(exp_gnt));
    chk("be_req", 32'(be_req), 32'(exp_req));
    chk("outstanding", 32'(outstanding), 32'(occ));
    chk("proto_err", 32'(proto_err), 32'(proto_cur));
    if (req) begin
      chk("be_add", be_add, dif.add);
      chk("be_wdata", be_wdata, dif.wdata);
      chk("be_we_be", {23'd0, be_we_n, be_be}, {23'd0, we_n, dif.be});
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_idle();
    model_ids.delete();
    exp_q.delete();
    proto_cur  = 1'b0;
    proto_nxt  = 1'b0;
    last_id    = '0;
    last_rdata = '0;
    last_opc   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_r_valid", 32'(dif.r_valid), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_r_id", 32'(dif.r_id), 32'd0);
    chk("rst_r_rdata", dif.r_rdata, 32'd0);
    chk("rst_r_opc", 32'(dif.r_opc), 32'd0);
    chk("rst_gnt", 32'(dif.gnt), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      logic rv;
      rv = (model_ids.size() > 0) && ($urandom_range(0, 2) != 0);
      do_cycle(1'($urandom_range(0, 1)), IW'($urandom), 1'($urandom),
               ($urandom_range(0, 3) != 0), rv, $urandom, 1'($urandom));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && model_ids.size() > 0; i++) begin
      do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, $urandom, 1'($urandom));
    end
    repeat (2) do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("model_drained", 32'(model_ids.size()), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    do_reset();

    // single read: id 3A, rvalid two cycles after the grant
    do_cycle(1'b1, 8'h3A, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0);
    repeat (2) do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);

    // back-to-back writes 1..4 fill the ID queue; a fifth request is refused
    for (int i = 1; i <= 4; i++) do_cycle(1'b1, IW'(i), 1'b0, 1'b1, 1'b0, '0, 1'b0);
    do_cycle(1'b1, 8'h05, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    // full with pop and request in the same cycle: grant only on the next cycle
    do_cycle(1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 32'h1111_0001, 1'b0);
    do_cycle(1'b1, 8'h05, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, $urandom, 1'b0);
    repeat (2) do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);

    // backend stall: request held with no backend grant
    repeat (5) do_cycle(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, '0, 1'b0);

    // error response for id 07
    do_cycle(1'b1, 8'h07, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'hDEAD_0007, 1'b1);
    repeat (2) do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);

    // random traffic, then a reset with transactions in flight
    random_cycles(400);
    for (int i = 0; i < 10 && model_ids.size() == 0; i++)
      do_cycle(1'b1, IW'($urandom), 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("inflight_before_reset", 32'(model_ids.size() > 0), 32'd1);
    do_reset();
    random_cycles(200);
    drain();

    // spurious backend response with nothing outstanding
    do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1);
    repeat (4) do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("proto_err_sticky", 32'(proto_err), 32'(ERR_EN));
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_periph_target_id
